cond_exec_unit: RTL and testbench
=================================

Name: cond_exec_unit

Overview:
- Conditional-execution stage sitting directly downstream of the multi-cycle main control FSM in the ARM-subset controller.
- Consumes the FSM's raw strobes (RegW, MemW, NextPC, Branch, ALUOp) plus instruction fields and ALU flags.
- Decodes the ALU command and holds the architectural NZCV flags.
- Evaluates the 4-bit condition field and produces the final gated PCWrite/RegWrite/MemWrite for the datapath.
- Also keeps saturating counters of executed and condition-annulled instructions.

Parameters:
- CNT_W, 16, width of the executed/annulled instruction counters.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- Cond  input  4  condition field, Instr[31:28]
- Funct  input  5  Funct[4:1] = ALU command (Instr[24:21]), Funct[0] = S bit
- Rd  input  4  destination register, Instr[15:12]
- ALUFlags  input  4  {N,Z,C,V} from the ALU this cycle
- ALUOp  input  1  from FSM; 1 = data-processing execute cycle
- RegW, MemW, NextPC, Branch  input  1 each  raw FSM strobes
- cnt_clr  input  1  synchronous clear of both counters
- ALUControl  output  2  00 add, 01 sub, 10 and, 11 orr
- PCWrite  output  1  gated PC write enable
- RegWrite  output  1  gated register-file write enable
- MemWrite  output  1  gated data-memory write enable
- Flags  output  4  registered {N,Z,C,V}
- CondEx  output  1  combinational condition result against registered Flags
- exec_cnt  output  CNT_W  executed instructions
- skip_cnt  output  CNT_W  annulled instructions

Behaviour:
- Reset (reset=0, asynchronous):
  - Flags=0000, internal CondExDelayed=0, exec_cnt=0, skip_cnt=0.
  - Therefore RegWrite=MemWrite=0 and PCWrite=NextPC while reset is held.
- ALU decode (combinational):
  - ALUOp=0: ALUControl=00, FlagW=00.
  - ALUOp=1, Funct[4:1]: 0100 ADD->00, 0010 SUB->01, 0000 AND->10, 1100 ORR->11; any other code ->00 with FlagW=00.
  - FlagW[1] (NZ write) = Funct[0].
  - FlagW[0] (CV write) = Funct[0] & (ADD|SUB).
- PCS = Branch | (RegW & Rd==4'hF).
- Condition evaluation, with N,Z,C,V taken from the Flags register:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V); D LE Z|(N!=V).
  - E AL 1; F treated as 1.
- Flag registers, updated on rising clk:
  - Flags[3:2] <= ALUFlags[3:2] iff FlagW[1] & CondEx.
  - Flags[1:0] <= ALUFlags[1:0] iff FlagW[0] & CondEx.
  - Otherwise hold.
- CondExDelayed <= CondEx every cycle. This is one-cycle latency, so write-back states use the condition sampled in the previous (execute/decode) cycle, before that cycle's flag update.
- Gated outputs (combinational):
  - PCWrite = NextPC | (PCS & CondExDelayed).
  - RegWrite = RegW & CondExDelayed.
  - MemWrite = MemW & CondExDelayed.
- Counters:
  - A cycle with qual = RegW|MemW|Branch is an instruction commit point.
  - If CondExDelayed=1, exec_cnt increments; else skip_cnt increments.
  - Both counters saturate at all-ones and never wrap.
  - cnt_clr=1 forces both counters to 0 next edge and wins over a simultaneous increment.
- Flags are unaffected by cnt_clr.
- Reset asserted mid-instruction clears all state immediately. No pending write survives reset.

Test Plan:
- Reset: hold reset=0 with RegW=MemW=1, NextPC=0 -> RegWrite=MemWrite=PCWrite=0, Flags=0000, counters 0. Release reset -> no output glitches.
- SUBS flag write: ALUOp=1, Funct=00101, Cond=E, ALUFlags=0110 for one cycle -> Flags=0110 next cycle, ALUControl=01. Repeat with Cond=0 (EQ, Z=1) and ALUFlags=1000 -> Flags=1000.
- ANDS partial write: Flags=0011, ALUOp=1, Funct=00001, ALUFlags=0100 -> Flags=0111, because C and V are held.
- Annulled write-back: Flags=0000, Cond=0 (EQ) in the execute cycle, then RegW=1 next cycle -> RegWrite=0 and skip_cnt 0->1. Same with Cond=1 (NE) -> RegWrite=1 and exec_cnt increments.
- PC/branch gating:
  - Branch=1, Cond=B (LT) with Flags N=1,V=0 held for two cycles -> PCWrite=1 in the second cycle.
  - With N=V=1 -> PCWrite=0.
  - RegW=1, Rd=F, Cond=E -> PCWrite=1.
- Counter saturation/clear with CNT_W=2: 5 executed commits -> exec_cnt=3. Then cnt_clr together with a commit -> exec_cnt=0.

Source files
------------

// File: rtl/cond_exec_unit_if.sv
// Bundle of the conditional-execution stage signals.
// ctrl modport (master): drives the FSM strobes, instruction fields, ALU flags
// and counter clear, and observes the gated enables, flags and counters.
// unit modport (slave): the cond_exec_unit side of the same bundle.
interface cond_exec_unit_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       Cond;
  logic [4:0]       Funct;
  logic [3:0]       Rd;
  logic [3:0]       ALUFlags;
  logic             ALUOp;
  logic             RegW;
  logic             MemW;
  logic             NextPC;
  logic             Branch;
  logic             cnt_clr;
  logic [1:0]       ALUControl;
  logic             PCWrite;
  logic             RegWrite;
  logic             MemWrite;
  logic [3:0]       Flags;
  logic             CondEx;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;

  modport master (
    output Cond, Funct, Rd, ALUFlags, ALUOp, RegW, MemW, NextPC, Branch, cnt_clr,
    input  ALUControl, PCWrite, RegWrite, MemWrite, Flags, CondEx, exec_cnt, skip_cnt
  );

  modport slave (
    input  Cond, Funct, Rd, ALUFlags, ALUOp, RegW, MemW, NextPC, Branch, cnt_clr,
    output ALUControl, PCWrite, RegWrite, MemWrite, Flags, CondEx, exec_cnt, skip_cnt
  );
endinterface

// File: rtl/cond_exec_unit.sv
// Conditional-execution stage for the ARM-subset controller.
// Decodes the ALU command, holds NZCV, evaluates the condition field and
// gates the FSM's raw PC/register/memory write strobes. Also counts executed
// and annulled instructions with saturating counters.
// Ports:
//   clk   - system clock (rising edge)
//   reset - asynchronous active-low reset
//   bus   - cond_exec_unit_if slave: FSM strobes, instruction fields,
//           ALU flags, cnt_clr in; ALUControl, PCWrite, RegWrite, MemWrite,
//           Flags, CondEx, exec_cnt, skip_cnt out
module cond_exec_unit #(
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  cond_exec_unit_if.slave   bus
);

  logic [1:0]       flag_w;
  logic             pcs;
  logic             cond_ex;
  logic             cond_ex_d;
  logic [3:0]       flags;
  logic [CNT_W-1:0] exec_cnt;
  logic [CNT_W-1:0] skip_cnt;
  logic             qual;
  logic             n, z, c, v;

  assign {n, z, c, v} = flags;

  // ALU decode; unknown commands fall back to ADD with no flag writes
  always_comb begin
    bus.ALUControl = 2'b00;
    flag_w         = 2'b00;
    if (bus.ALUOp) begin
      unique case (bus.Funct[4:1])
        4'b0100: begin bus.ALUControl = 2'b00; flag_w = {bus.Funct[0], bus.Funct[0]}; end
        4'b0010: begin bus.ALUControl = 2'b01; flag_w = {bus.Funct[0], bus.Funct[0]}; end
        4'b0000: begin bus.ALUControl = 2'b10; flag_w = {bus.Funct[0], 1'b0}; end
        4'b1100: begin bus.ALUControl = 2'b11; flag_w = {bus.Funct[0], 1'b0}; end
        default: begin bus.ALUControl = 2'b00; flag_w = 2'b00; end
      endcase
    end
  end

  always_comb begin
    cond_ex = 1'b1;
    unique case (bus.Cond)
      4'h0: cond_ex = z;
      4'h1: cond_ex = ~z;
      4'h2: cond_ex = c;
      4'h3: cond_ex = ~c;
      4'h4: cond_ex = n;
      4'h5: cond_ex = ~n;
      4'h6: cond_ex = v;
      4'h7: cond_ex = ~v;
      4'h8: cond_ex = c & ~z;
      4'h9: cond_ex = ~c | z;
      4'hA: cond_ex = (n == v);
      4'hB: cond_ex = (n != v);
      4'hC: cond_ex = ~z & (n == v);
      4'hD: cond_ex = z | (n != v);
      default: cond_ex = 1'b1;
    endcase
  end

  assign pcs  = bus.Branch | (bus.RegW & (bus.Rd == 4'hF));
  assign qual = bus.RegW | bus.MemW | bus.Branch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags     <= '0;
      cond_ex_d <= 1'b0;
      exec_cnt  <= '0;
      skip_cnt  <= '0;
    end else begin
      if (flag_w[1] & cond_ex) flags[3:2] <= bus.ALUFlags[3:2];
      if (flag_w[0] & cond_ex) flags[1:0] <= bus.ALUFlags[1:0];
      cond_ex_d <= cond_ex;
      if (bus.cnt_clr) begin
        exec_cnt <= '0;
        skip_cnt <= '0;
      end else if (qual) begin
        // commit is judged by the condition latched in the previous cycle
        if (cond_ex_d) begin
          if (exec_cnt != '1) exec_cnt <= exec_cnt + 1'b1;
        end else begin
          if (skip_cnt != '1) skip_cnt <= skip_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.PCWrite  = bus.NextPC | (pcs & cond_ex_d);
  assign bus.RegWrite = bus.RegW & cond_ex_d;
  assign bus.MemWrite = bus.MemW & cond_ex_d;
  assign bus.Flags    = flags;
  assign bus.CondEx   = cond_ex;
  assign bus.exec_cnt = exec_cnt;
  assign bus.skip_cnt = skip_cnt;

endmodule

// File: tb/tb_cond_exec_unit.sv
module tb_cond_exec_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond;
  logic [4:0] Funct;
  logic [3:0] Rd;
  logic [3:0] ALUFlags;
  logic       ALUOp, RegW, MemW, NextPC, Branch, cnt_clr;

  int checks = 0;
  int errors = 0;

  // reference state
  bit [3:0] m_flags;
  bit       m_cd;
  int       m_exec16, m_skip16, m_exec2, m_skip2;

  cond_exec_unit_if #(.CNT_W(16)) b16 ();
  cond_exec_unit_if #(.CNT_W(2))  b2 ();

  assign b16.Cond = Cond;      assign b2.Cond = Cond;
  assign b16.Funct = Funct;    assign b2.Funct = Funct;
  assign b16.Rd = Rd;          assign b2.Rd = Rd;
  assign b16.ALUFlags = ALUFlags; assign b2.ALUFlags = ALUFlags;
  assign b16.ALUOp = ALUOp;    assign b2.ALUOp = ALUOp;
  assign b16.RegW = RegW;      assign b2.RegW = RegW;
  assign b16.MemW = MemW;      assign b2.MemW = MemW;
  assign b16.NextPC = NextPC;  assign b2.NextPC = NextPC;
  assign b16.Branch = Branch;  assign b2.Branch = Branch;
  assign b16.cnt_clr = cnt_clr; assign b2.cnt_clr = cnt_clr;

  cond_exec_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset(reset), .bus(b16));
  cond_exec_unit #(.CNT_W(2))  dut2  (.clk(clk), .reset(reset), .bus(b2));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Conditions come in complementary pairs: odd codes invert the even one.
  function automatic bit cond_ok(int cond, bit [3:0] f);
    bit n, z, c, v;
    bit base [7];
    {n, z, c, v} = f;
    base = '{z, c, n, v, c && !z, n == v, !z && (n == v)};
    if (cond >= 14) return 1'b1;
    return base[cond / 2] ^ bit'(cond % 2);
  endfunction

  function automatic int sat_inc(int val, int width);
    int top = (1 << width) - 1;
    return (val < top) ? val + 1 : val;
  endfunction

  task automatic drive(input int cnd, input int fn, input int rd, input int af,
                       input bit aop, input bit rw, input bit mw, input bit npc,
                       input bit br, input bit clr);
    Cond = 4'(cnd); Funct = 5'(fn); Rd = 4'(rd); ALUFlags = 4'(af);
    ALUOp = aop; RegW = rw; MemW = mw; NextPC = npc; Branch = br; cnt_clr = clr;
    #1;
  endtask

  // Checks all outputs against the model, then advances model and DUT one clock.
  task automatic cycle();
    int  cmd;
    bit  known, is_arith, cex, pcs, qual;
    int  exp_ctrl;
    bit [1:0] fw;
    if (!reset) begin
      m_flags = '0; m_cd = 0; m_exec16 = 0; m_skip16 = 0; m_exec2 = 0; m_skip2 = 0;
    end
    cmd = int'(Funct[4:1]);
    known    = ALUOp && (cmd == 4 || cmd == 2 || cmd == 0 || cmd == 12);
    is_arith = (cmd == 4 || cmd == 2);
    exp_ctrl = !known ? 0 : (cmd == 4) ? 0 : (cmd == 2) ? 1 : (cmd == 0) ? 2 : 3;
    fw  = known ? {Funct[0], Funct[0] && is_arith} : 2'b00;
    cex = cond_ok(int'(Cond), m_flags);
    pcs = Branch || (RegW && Rd == 4'hF);
    qual = RegW || MemW || Branch;

    chk("ALUControl", 32'(b16.ALUControl), 32'(exp_ctrl));
    chk("CondEx",     32'(b16.CondEx), 32'(cex));
    chk("PCWrite",    32'(b16.PCWrite), 32'(NextPC || (pcs && m_cd)));
    chk("RegWrite",   32'(b16.RegWrite), 32'(RegW && m_cd));
    chk("MemWrite",   32'(b16.MemWrite), 32'(MemW && m_cd));
    chk("Flags",      32'(b16.Flags), 32'(m_flags));
    chk("exec_cnt16", 32'(b16.exec_cnt), 32'(m_exec16));
    chk("skip_cnt16", 32'(b16.skip_cnt), 32'(m_skip16));
    chk("exec_cnt2",  32'(b2.exec_cnt), 32'(m_exec2));
    chk("skip_cnt2",  32'(b2.skip_cnt), 32'(m_skip2));

    @(posedge clk);
    if (reset) begin
      if (fw[1] && cex) m_flags[3:2] = ALUFlags[3:2];
      if (fw[0] && cex) m_flags[1:0] = ALUFlags[1:0];
      if (cnt_clr) begin
        m_exec16 = 0; m_skip16 = 0; m_exec2 = 0; m_skip2 = 0;
      end else if (qual) begin
        if (m_cd) begin
          m_exec16 = sat_inc(m_exec16, 16); m_exec2 = sat_inc(m_exec2, 2);
        end else begin
          m_skip16 = sat_inc(m_skip16, 16); m_skip2 = sat_inc(m_skip2, 2);
        end
      end
      m_cd = cex;
    end
    @(negedge clk);
  endtask

  initial begin
    int f;
    reset = 1'b0;
    drive(14, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    @(negedge clk);
    // reset held with raw write strobes high
    chk("rst_RegWrite", 32'(b16.RegWrite), 32'd0);
    chk("rst_MemWrite", 32'(b16.MemWrite), 32'd0);
    chk("rst_PCWrite",  32'(b16.PCWrite), 32'd0);
    cycle(); cycle();
    reset = 1'b1;
    drive(14, 0, 0, 0, 0, 0, 0, 0, 0, 0); cycle();

    // SUBS, always
    drive(14, 5'b00101, 0, 4'b0110, 1, 0, 0, 0, 0, 0);
    chk("subs_ctrl", 32'(b16.ALUControl), 32'd1);
    cycle();
    chk("subs_flags", 32'(b16.Flags), 32'h6);
    // SUBS, EQ with Z=1
    drive(0, 5'b00101, 0, 4'b1000, 1, 0, 0, 0, 0, 0); cycle();
    chk("subs_eq_flags", 32'(b16.Flags), 32'h8);

    // ADDS to get 0011, then ANDS partial write
    drive(14, 5'b01001, 0, 4'b0011, 1, 0, 0, 0, 0, 0); cycle();
    drive(14, 5'b00001, 0, 4'b0100, 1, 0, 0, 0, 0, 0); cycle();
    chk("ands_flags", 32'(b16.Flags), 32'h7);

    // annulled / executed write-back with Flags=0000
    drive(14, 5'b01001, 0, 4'b0000, 1, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 3, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(0, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("eq_annul_RegWrite", 32'(b16.RegWrite), 32'd0);
    cycle();
    drive(1, 0, 3, 0, 0, 0, 0, 0, 0, 0); cycle();
    drive(1, 0, 3, 0, 0, 1, 0, 0, 0, 0);
    chk("ne_exec_RegWrite", 32'(b16.RegWrite), 32'd1);
    cycle();

    // branch LT with N=1,V=0 then N=V=1
    drive(14, 5'b01001, 0, 4'b1000, 1, 0, 0, 0, 0, 0); cycle();
    drive(11, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    chk("lt_taken_PCWrite", 32'(b16.PCWrite), 32'd1);
    cycle();
    drive(14, 5'b01001, 0, 4'b1001, 1, 0, 0, 0, 0, 0); cycle();
    drive(11, 0, 0, 0, 0, 0, 0, 0, 1, 0); cycle();
    chk("lt_nottaken_PCWrite", 32'(b16.PCWrite), 32'd0);
    cycle();
    // register write to PC
    drive(14, 0, 15, 0, 0, 1, 0, 0, 0, 0); cycle();
    chk("rd15_PCWrite", 32'(b16.PCWrite), 32'd1);
    cycle();

    // saturation on the narrow instance, then clear racing a commit
    drive(14, 0, 1, 0, 0, 0, 0, 0, 0, 1); cycle();
    drive(14, 0, 1, 0, 0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cycle();
    chk("sat_exec_cnt2", 32'(b2.exec_cnt), 32'd3);
    drive(14, 0, 1, 0, 0, 1, 0, 0, 0, 1); cycle();
    chk("clr_exec_cnt2", 32'(b2.exec_cnt), 32'd0);
    chk("clr_exec_cnt16", 32'(b16.exec_cnt), 32'd0);

    // randomized traffic, with occasional asynchronous reset
    for (int i = 0; i < 600; i++) begin
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
          : ({$urandom_range(0, 3)} == 0 ? 8 : {$urandom_range(0, 3)} == 1 ? 4 : 0) + int'($urandom_range(0, 1))
            + (($urandom_range(0, 1) == 1) ? 24 : 0);
      reset = ($urandom_range(0, 79) != 0);
      drive(int'($urandom_range(0, 15)), f, int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 39) == 0));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
